ocm_dual_port_wc: RTL and testbench
===================================

Name: ocm_dual_port_wc

Overview:
- Parametrised true-dual-port on-chip RAM with width conversion.
- A narrow port (s1) and a wide port (s2, byte-enabled) share one storage array.
- Generalises the fixed 8-bit/64-bit on-chip memory: configurable width ratio, depth and read latency, plus readdatavalid handshakes and write-collision detection.
- Sits on the Avalon-MM fabric as the shared buffer between the byte-wide producer and the 64-bit DMA path.

Parameters:
- NARROW_W, 8: s1 data width in bits; must be a multiple of 8.
- RATIO, 8: wide/narrow width ratio; power of 2, range 1..16. WIDE_W = NARROW_W*RATIO.
- WIDE_AW, 14: s2 word-address width. Depth is 2^WIDE_AW wide words.
- NARROW_AW, WIDE_AW+log2(RATIO): s1 address width (derived localparam, not overridable).
- RD_LAT, 1: read latency in enabled cycles; legal values 1 or 2. 2 adds an output register.

Ports:
- clk_clk  in  1  single clock for both ports
- reset_reset  in  1  synchronous, active-high reset
- s1_address  in  NARROW_AW  narrow lane address
- s1_chipselect  in  1  port select
- s1_clken  in  1  port clock enable; 0 freezes the port
- s1_write  in  1  1 = write, 0 = read
- s1_writedata  in  NARROW_W  write data
- s1_readdata  out  NARROW_W  read data
- s1_readdatavalid  out  1  one-cycle strobe, read data valid
- s2_address  in  WIDE_AW  wide word address
- s2_chipselect  in  1  port select
- s2_clken  in  1  port clock enable
- s2_write  in  1  1 = write, 0 = read
- s2_writedata  in  WIDE_W  write data
- s2_byteenable  in  WIDE_W/8  per-byte write enable
- s2_readdata  out  WIDE_W  read data
- s2_readdatavalid  out  1  one-cycle strobe, read data valid
- collision  out  1  one-cycle pulse on a same-cycle overlapping write

Behaviour:
- Lane mapping is little-endian.
  - s1 word = s1_address >> log2(RATIO).
  - s1 lane k = s1_address[log2(RATIO)-1:0].
  - Lane k occupies wide bits [k*NARROW_W +: NARROW_W].
- Transaction accept: chipselect & clken & !reset_reset. Write if write=1, read otherwise.
- s2 write updates only bytes with byteenable=1. byteenable=0 on a write is a no-op.
- s2 read ignores byteenable and returns the full word.
- Read timing:
  - readdata and readdatavalid appear RD_LAT enabled cycles after the accept.
  - readdatavalid is high for exactly one enabled cycle per accepted read.
  - Back-to-back reads are supported at full throughput.
- clken=0 on a port stalls that port's pipeline: readdata, readdatavalid and in-flight stages all hold. The other port is unaffected.
- readdata holds its last value between reads. Write cycles do not update readdata.
- Collision (both ports write the same byte in one cycle): s2 data wins for the overlapping bytes. collision=1 on the next cycle for one cycle.
- Cross-port read-during-write (one port reads a word the other port writes in the same cycle): returns OLD data, unless the optional feature is enabled.
- Reset:
  - readdata=0, readdatavalid=0, collision=0.
  - In-flight reads are discarded; no valid strobe is issued for them.
  - Memory contents are not cleared.
  - Writes presented while reset is high are ignored.
- Out-of-range addresses cannot occur; address widths exactly cover the depth.

Optional Feature:
- Macro: OCM_RDW_FWD_EN.
- Defined: on a cross-port read-during-write to the same word, the read returns NEW data.
  - s2 reading under an s1 write: merged with the written lane.
  - s1 reading under an s2 write: the s2 byte-enabled bytes are forwarded.
- Undefined: old data is returned, with no forwarding logic.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- RD_LAT=1. s2 writes 0x0807060504030201 to word 5 with be=0xFF. s1 reads addresses 40..47 -> readdata 0x01..0x08, each valid 1 cycle after accept.
- s1 writes 0xAA to address 43. s2 reads word 5 -> 0x08070605AA030201 with readdatavalid after 1 cycle. With RD_LAT=2 -> after 2 cycles.
- Same cycle: s2 writes word 7 with 0xFFFF_FFFF_FFFF_FFFF, be=0x01; s1 writes 0x55 to address 56. Result: collision pulses once, and byte 0 of word 7 reads back 0xFF.
- s1 reads with clken dropped for 3 cycles mid-pipeline -> readdatavalid is delayed 3 cycles and the data is unchanged.
- Reset asserted one cycle after an s2 read accept -> no readdatavalid strobe, readdata=0, and previously written word 5 is still intact.
- s1 reads address 40 while s2 writes word 5 with 0xEE in byte 0, same cycle -> readdata 0x01 without OCM_RDW_FWD_EN, 0xEE with it.

Source files
------------

// File: rtl/ocm_dual_port_wc.sv
// True-dual-port RAM: narrow lane port s1 and wide byte-enabled port s2 share one array.
// Define OCM_RDW_FWD_EN to forward same-cycle cross-port write data into reads (new-data RDW).
module ocm_dual_port_wc #(
    parameter int NARROW_W = 8,
    parameter int RATIO    = 8,
    parameter int WIDE_AW  = 14,
    parameter int RD_LAT   = 1
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset,
    input  logic [WIDE_AW+$clog2(RATIO)-1:0]   s1_address,
    input  logic                               s1_chipselect,
    input  logic                               s1_clken,
    input  logic                               s1_write,
    input  logic [NARROW_W-1:0]                s1_writedata,
    output logic [NARROW_W-1:0]                s1_readdata,
    output logic                               s1_readdatavalid,
    input  logic [WIDE_AW-1:0]                 s2_address,
    input  logic                               s2_chipselect,
    input  logic                               s2_clken,
    input  logic                               s2_write,
    input  logic [NARROW_W*RATIO-1:0]          s2_writedata,
    input  logic [NARROW_W*RATIO/8-1:0]        s2_byteenable,
    output logic [NARROW_W*RATIO-1:0]          s2_readdata,
    output logic                               s2_readdatavalid,
    output logic                               collision
);

    localparam int WIDE_W = NARROW_W * RATIO;
    localparam int LOG2R  = $clog2(RATIO);
    localparam int LANE_W = (LOG2R > 0) ? LOG2R : 1;
    localparam int NB     = NARROW_W / 8;
    localparam int WB     = WIDE_W / 8;
    localparam int DEPTH  = 2 ** WIDE_AW;

    logic [WIDE_W-1:0]   mem [DEPTH];

    logic                s1_acc, s1_wr, s1_rd;
    logic                s2_acc, s2_wr, s2_rd;
    logic [WIDE_AW-1:0]  s1_word;
    logic [LANE_W-1:0]   s1_lane;
    logic [WB-1:0]       s1_lane_be;
    logic [WIDE_W-1:0]   s1_row, s2_row;
    logic [NARROW_W-1:0] s1_lane_rd;

    logic [NARROW_W-1:0] s1_q;
    logic                s1_q_vld;
    logic [WIDE_W-1:0]   s2_q;
    logic                s2_q_vld;

    assign s1_acc = s1_chipselect && s1_clken && !reset_reset;
    assign s1_wr  = s1_acc && s1_write;
    assign s1_rd  = s1_acc && !s1_write;
    assign s2_acc = s2_chipselect && s2_clken && !reset_reset;
    assign s2_wr  = s2_acc && s2_write;
    assign s2_rd  = s2_acc && !s2_write;

    // Little-endian lane split of the narrow address
    if (LOG2R == 0) begin : g_ratio1
        assign s1_word = s1_address;
        assign s1_lane = '0;
    end else begin : g_ratio_n
        assign s1_word = s1_address[LOG2R +: WIDE_AW];
        assign s1_lane = s1_address[LOG2R-1:0];
    end

    assign s1_lane_be = WB'({NB{1'b1}}) << (NB * s1_lane);

    // Array reads see pre-write contents unless forwarding is built in
    always_comb begin
        s1_row = mem[s1_word];
        s2_row = mem[s2_address];
`ifdef OCM_RDW_FWD_EN
        if (s2_wr && (s2_address == s1_word)) begin
            for (int b = 0; b < WB; b++) begin
                if (s2_byteenable[b])
                    s1_row[b*8 +: 8] = s2_writedata[b*8 +: 8];
            end
        end
        if (s1_wr && (s1_word == s2_address))
            s2_row[s1_lane*NARROW_W +: NARROW_W] = s1_writedata;
`endif
        s1_lane_rd = s1_row[s1_lane*NARROW_W +: NARROW_W];
    end

    // s2 is applied last so it owns any byte both ports write in the same cycle
    always_ff @(posedge clk_clk) begin
        if (s1_wr)
            mem[s1_word][s1_lane*NARROW_W +: NARROW_W] <= s1_writedata;
        if (s2_wr) begin
            for (int b = 0; b < WB; b++) begin
                if (s2_byteenable[b])
                    mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            collision <= 1'b0;
        else
            collision <= s1_wr && s2_wr && (s1_word == s2_address)
                         && (|(s1_lane_be & s2_byteenable));
    end

    // First read stage; each port advances only on its own clock enable
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q     <= '0;
            s1_q_vld <= 1'b0;
            s2_q     <= '0;
            s2_q_vld <= 1'b0;
        end else begin
            if (s1_clken) begin
                s1_q_vld <= s1_rd;
                if (s1_rd)
                    s1_q <= s1_lane_rd;
            end
            if (s2_clken) begin
                s2_q_vld <= s2_rd;
                if (s2_rd)
                    s2_q <= s2_row;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [NARROW_W-1:0] s1_q2;
        logic                s1_q2_vld;
        logic [WIDE_W-1:0]   s2_q2;
        logic                s2_q2_vld;

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                s1_q2     <= '0;
                s1_q2_vld <= 1'b0;
                s2_q2     <= '0;
                s2_q2_vld <= 1'b0;
            end else begin
                if (s1_clken) begin
                    s1_q2_vld <= s1_q_vld;
                    if (s1_q_vld)
                        s1_q2 <= s1_q;
                end
                if (s2_clken) begin
                    s2_q2_vld <= s2_q_vld;
                    if (s2_q_vld)
                        s2_q2 <= s2_q;
                end
            end
        end

        assign s1_readdata      = s1_q2;
        assign s1_readdatavalid = s1_q2_vld;
        assign s2_readdata      = s2_q2;
        assign s2_readdatavalid = s2_q2_vld;
    end else begin : g_lat1
        assign s1_readdata      = s1_q;
        assign s1_readdatavalid = s1_q_vld;
        assign s2_readdata      = s2_q;
        assign s2_readdatavalid = s2_q_vld;
    end

endmodule

// File: tb/tb_ocm_dual_port_wc.sv
// Bench for ocm_dual_port_wc: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// checked each cycle against a byte-array memory model with per-port read-age queues.
module tb_ocm_dual_port_wc;

    localparam int RATIO   = 8;
    localparam int WIDE_AW = 14;
    localparam int TOP_W   = (1 << WIDE_AW) - 1;

    logic        clk;
    logic        reset;
    logic [16:0] s1_address;
    logic        s1_cs, s1_clken, s1_write;
    logic [7:0]  s1_wdata;
    logic [13:0] s2_address;
    logic        s2_cs, s2_clken, s2_write;
    logic [63:0] s2_wdata;
    logic [7:0]  s2_be;

    logic [7:0]  d1_s1_rd, d2_s1_rd;
    logic        d1_s1_vld, d2_s1_vld;
    logic [63:0] d1_s2_rd, d2_s2_rd;
    logic        d1_s2_vld, d2_s2_vld;
    logic        d1_col, d2_col;

    int checks   = 0;
    int failures = 0;

    ocm_dual_port_wc #(.NARROW_W(8), .RATIO(RATIO), .WIDE_AW(WIDE_AW), .RD_LAT(1)) dut1 (
        .clk_clk(clk), .reset_reset(reset),
        .s1_address(s1_address), .s1_chipselect(s1_cs), .s1_clken(s1_clken),
        .s1_write(s1_write), .s1_writedata(s1_wdata),
        .s1_readdata(d1_s1_rd), .s1_readdatavalid(d1_s1_vld),
        .s2_address(s2_address), .s2_chipselect(s2_cs), .s2_clken(s2_clken),
        .s2_write(s2_write), .s2_writedata(s2_wdata), .s2_byteenable(s2_be),
        .s2_readdata(d1_s2_rd), .s2_readdatavalid(d1_s2_vld), .collision(d1_col)
    );

    ocm_dual_port_wc #(.NARROW_W(8), .RATIO(RATIO), .WIDE_AW(WIDE_AW), .RD_LAT(2)) dut2 (
        .clk_clk(clk), .reset_reset(reset),
        .s1_address(s1_address), .s1_chipselect(s1_cs), .s1_clken(s1_clken),
        .s1_write(s1_write), .s1_writedata(s1_wdata),
        .s1_readdata(d2_s1_rd), .s1_readdatavalid(d2_s1_vld),
        .s2_address(s2_address), .s2_chipselect(s2_cs), .s2_clken(s2_clken),
        .s2_write(s2_write), .s2_writedata(s2_wdata), .s2_byteenable(s2_be),
        .s2_readdata(d2_s2_rd), .s2_readdatavalid(d2_s2_vld), .collision(d2_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          tag;
    } rd_rec_t;

    logic [63:0] mem_m [1 << WIDE_AW];
    rd_rec_t     s1_q[$];
    rd_rec_t     s2_q[$];
    int          s1_en = 0;
    int          s2_en = 0;
    logic [63:0] exp_s1_rd [2];
    logic [63:0] exp_s2_rd [2];
    logic        exp_s1_vld [2];
    logic        exp_s2_vld [2];
    logic        exp_col;
    bit          model_live = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a read is visible while exactly RD_LAT-1 enabled edges have passed since its accept edge
    task automatic model_step();
        logic [63:0] d1, d2;
        int          word1, lane1;
        bit          w1, r1, w2, r2;
        if (reset) begin
            s1_q.delete();
            s2_q.delete();
            for (int l = 0; l < 2; l++) begin
                exp_s1_rd[l] = '0; exp_s1_vld[l] = 1'b0;
                exp_s2_rd[l] = '0; exp_s2_vld[l] = 1'b0;
            end
            exp_col    = 1'b0;
            model_live = 1'b1;
            return;
        end
        w1 = s1_cs && s1_clken && s1_write;
        r1 = s1_cs && s1_clken && !s1_write;
        w2 = s2_cs && s2_clken && s2_write;
        r2 = s2_cs && s2_clken && !s2_write;
        word1 = int'(s1_address) / RATIO;
        lane1 = int'(s1_address) % RATIO;
        d1 = 64'(mem_m[word1][lane1*8 +: 8]);
        d2 = mem_m[s2_address];
`ifdef OCM_RDW_FWD_EN
        if (w2 && word1 == int'(s2_address) && s2_be[lane1])
            d1 = 64'(s2_wdata[lane1*8 +: 8]);
        if (w1 && word1 == int'(s2_address))
            d2[lane1*8 +: 8] = s1_wdata;
`endif
        exp_col = w1 && w2 && (word1 == int'(s2_address)) && s2_be[lane1];
        if (w1)
            mem_m[word1][lane1*8 +: 8] = s1_wdata;
        if (w2) begin
            for (int b = 0; b < 8; b++)
                if (s2_be[b]) mem_m[s2_address][b*8 +: 8] = s2_wdata[b*8 +: 8];
        end
        if (s1_clken) begin
            s1_en++;
            if (r1) s1_q.push_back('{data: d1, tag: s1_en});
            for (int l = 0; l < 2; l++) begin
                exp_s1_vld[l] = 1'b0;
                foreach (s1_q[i])
                    if (s1_en - s1_q[i].tag == l) begin
                        exp_s1_vld[l] = 1'b1;
                        exp_s1_rd[l]  = s1_q[i].data;
                    end
            end
            while (s1_q.size() > 0 && s1_en - s1_q[0].tag >= 1) void'(s1_q.pop_front());
        end
        if (s2_clken) begin
            s2_en++;
            if (r2) s2_q.push_back('{data: d2, tag: s2_en});
            for (int l = 0; l < 2; l++) begin
                exp_s2_vld[l] = 1'b0;
                foreach (s2_q[i])
                    if (s2_en - s2_q[i].tag == l) begin
                        exp_s2_vld[l] = 1'b1;
                        exp_s2_rd[l]  = s2_q[i].data;
                    end
            end
            while (s2_q.size() > 0 && s2_en - s2_q[0].tag >= 1) void'(s2_q.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check_output("lat1_s1_rdata", 64'(d1_s1_rd),  exp_s1_rd[0]);
            check_output("lat1_s1_valid", 64'(d1_s1_vld), 64'(exp_s1_vld[0]));
            check_output("lat1_s2_rdata", d1_s2_rd,       exp_s2_rd[0]);
            check_output("lat1_s2_valid", 64'(d1_s2_vld), 64'(exp_s2_vld[0]));
            check_output("lat1_collision", 64'(d1_col),   64'(exp_col));
            check_output("lat2_s1_rdata", 64'(d2_s1_rd),  exp_s1_rd[1]);
            check_output("lat2_s1_valid", 64'(d2_s1_vld), 64'(exp_s1_vld[1]));
            check_output("lat2_s2_rdata", d2_s2_rd,       exp_s2_rd[1]);
            check_output("lat2_s2_valid", 64'(d2_s2_vld), 64'(exp_s2_vld[1]));
            check_output("lat2_collision", 64'(d2_col),   64'(exp_col));
        end
    end

    // Drive one cycle of traffic on both ports, then move to the next sampling point
    task automatic apply_stimulus(input bit a_cs, input bit a_wr, input logic [16:0] a_addr,
                                  input logic [7:0] a_data, input bit b_cs, input bit b_wr,
                                  input logic [13:0] b_addr, input logic [63:0] b_data,
                                  input logic [7:0] b_be);
        s1_cs = a_cs; s1_write = a_wr; s1_address = a_addr; s1_wdata = a_data;
        s2_cs = b_cs; s2_write = b_wr; s2_address = b_addr; s2_wdata = b_data; s2_be = b_be;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; s1_clken = 1'b1; s2_clken = 1'b1;
        s1_cs = 0; s1_write = 0; s1_address = '0; s1_wdata = '0;
        s2_cs = 0; s2_write = 0; s2_address = '0; s2_wdata = '0; s2_be = '0;
        repeat (3) @(negedge clk);
        check_output("reset_s1_rdata", 64'(d1_s1_rd), 64'h0);
        check_output("reset_s2_valid", 64'(d2_s2_vld), 64'h0);
        check_output("reset_collision", 64'(d1_col), 64'h0);
        reset = 1'b0;

        $display("[TB] preloading words 0..15 and top word");
        for (int w = 0; w < 16; w++)
            apply_stimulus(0, 0, '0, '0, 1, 1, 14'(w), {$urandom(), $urandom()}, 8'hFF);
        apply_stimulus(0, 0, '0, '0, 1, 1, 14'(TOP_W), 64'h1122334455667788, 8'hFF);

        $display("[TB] lane mapping");
        apply_stimulus(0, 0, '0, '0, 1, 1, 14'd5, 64'h0807060504030201, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 0, 17'(40 + i), '0, 0, 0, '0, '0, '0);
            check_output("lane_read_data", 64'(d1_s1_rd), 64'(i + 1));
            check_output("lane_read_valid", 64'(d1_s1_vld), 64'h1);
        end

        apply_stimulus(1, 1, 17'd43, 8'hAA, 0, 0, '0, '0, '0);
        apply_stimulus(0, 0, '0, '0, 1, 0, 14'd5, '0, 8'h00);
        check_output("wide_read_lat1", d1_s2_rd, 64'h08070605AA030201);
        check_output("wide_valid_lat2_early", 64'(d2_s2_vld), 64'h0);
        idle_cycle();
        check_output("wide_read_lat2", d2_s2_rd, 64'h08070605AA030201);
        check_output("wide_valid_lat2", 64'(d2_s2_vld), 64'h1);

        $display("[TB] collision");
        apply_stimulus(1, 1, 17'd56, 8'h55, 1, 1, 14'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
        check_output("collision_pulse", 64'(d1_col), 64'h1);
        apply_stimulus(1, 0, 17'd56, '0, 0, 0, '0, '0, '0);
        check_output("collision_drop", 64'(d1_col), 64'h0);
        check_output("collision_winner", 64'(d1_s1_rd), 64'hFF);
        apply_stimulus(1, 1, 17'd57, 8'h66, 1, 1, 14'd7, 64'h0, 8'h01);
        check_output("no_collision_other_lane", 64'(d2_col), 64'h0);

        $display("[TB] clock-enable stall");
        apply_stimulus(1, 0, 17'd41, '0, 0, 0, '0, '0, '0);
        check_output("stall_accept_lat1", 64'(d1_s1_rd), 64'h02);
        s1_clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 17'd47, '0, 1, 0, 14'd5, '0, '0);
            check_output("stall_lat2_hold", 64'(d2_s1_vld), 64'h0);
        end
        s1_clken = 1'b1;
        idle_cycle();
        check_output("stall_release_valid", 64'(d2_s1_vld), 64'h1);
        check_output("stall_release_data", 64'(d2_s1_rd), 64'h02);

        $display("[TB] reset mid-read");
        apply_stimulus(0, 0, '0, '0, 1, 0, 14'd5, '0, '0);
        reset = 1'b1;
        apply_stimulus(1, 1, 17'd44, 8'h77, 0, 0, '0, '0, '0);
        check_output("reset_drops_valid", 64'(d2_s2_vld), 64'h0);
        check_output("reset_clears_rdata", d2_s2_rd, 64'h0);
        reset = 1'b0;
        apply_stimulus(0, 0, '0, '0, 1, 0, 14'd5, '0, '0);
        check_output("reset_keeps_memory", d1_s2_rd, 64'h08070605AA030201);
        apply_stimulus(1, 0, 17'd44, '0, 0, 0, '0, '0, '0);
        check_output("reset_write_ignored", 64'(d1_s1_rd), 64'h05);

        $display("[TB] cross-port read-during-write");
        apply_stimulus(1, 0, 17'd40, '0, 1, 1, 14'd5, 64'h0000_0000_0000_00EE, 8'h01);
`ifdef OCM_RDW_FWD_EN
        check_output("rdw_s1_under_s2", 64'(d1_s1_rd), 64'hEE);
`else
        check_output("rdw_s1_under_s2", 64'(d1_s1_rd), 64'h01);
`endif
        apply_stimulus(1, 1, 17'd41, 8'h3C, 1, 0, 14'd5, '0, '0);
`ifdef OCM_RDW_FWD_EN
        check_output("rdw_s2_under_s1", d1_s2_rd, 64'h08070605AA033CEE);
`else
        check_output("rdw_s2_under_s1", d1_s2_rd, 64'h08070605AA0302EE);
`endif

        $display("[TB] top word boundary");
        apply_stimulus(1, 1, 17'h1FFFF, 8'h99, 0, 0, '0, '0, '0);
        apply_stimulus(1, 0, 17'h1FFF8, '0, 1, 0, 14'(TOP_W), '0, '0);
        check_output("top_word_merge", d1_s2_rd, 64'h9922334455667788);
        check_output("top_word_lane0", 64'(d1_s1_rd), 64'h88);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            int w1, w2;
            w1 = ($urandom_range(0, 15) == 0) ? TOP_W : int'($urandom_range(0, 15));
            w2 = ($urandom_range(0, 15) == 0) ? TOP_W : int'($urandom_range(0, 15));
            reset      = ($urandom_range(0, 199) == 0);
            s1_clken   = ($urandom_range(0, 3) != 0);
            s2_clken   = ($urandom_range(0, 3) != 0);
            s1_cs      = ($urandom_range(0, 2) != 0);
            s2_cs      = ($urandom_range(0, 2) != 0);
            s1_write   = $urandom_range(0, 1) == 1;
            s2_write   = $urandom_range(0, 1) == 1;
            s1_address = 17'(w1 * RATIO + int'($urandom_range(0, RATIO - 1)));
            s2_address = 14'(w2);
            s1_wdata   = 8'($urandom());
            s2_wdata   = {$urandom(), $urandom()};
            s2_be      = 8'($urandom());
            @(negedge clk);
        end
        reset = 1'b0; s1_clken = 1'b1; s2_clken = 1'b1;
        repeat (4) idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
